address_decoder_sync: RTL and testbench

Registered, parametrised successor to the UART combinational address decoder. It accepts a bus request carrying an `ADDR_WIDTH`-bit address and asserts one one-hot target select for a programmable number of wait states. It then returns a single-cycle acknowledge. It sits between the software-defined UART's bus master and its register/peripheral targets, and adds handshaking, wait-state timing and unmapped-address handling that the combinational decoder lacks.

---
 rtl/address_decoder_sync_if.sv | 23 ++
 rtl/address_decoder_sync.sv | 146 ++++++++++++++
 tb/tb_address_decoder_sync.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/address_decoder_sync_if.sv
// Bus bundle between the UART bus master and the registered address decoder.
// The master drives address/request; the decoder returns select, ack, error and busy.
interface address_decoder_sync_if #(
    parameter int ADDR_WIDTH  = 3,
    parameter int NUM_TARGETS = 8
);
    logic [ADDR_WIDTH-1:0]  addressIn;
    logic                   request;
    logic [NUM_TARGETS-1:0] decodedAddress;
    logic                   ack;
    logic                   error;
    logic                   busy;

    modport master (
        output addressIn, request,
        input  decodedAddress, ack, error, busy
    );

    modport slave (
        input  addressIn, request,
        output decodedAddress, ack, error, busy
    );
endinterface

// File: rtl/address_decoder_sync.sv
// Registered one-hot address decoder with wait states, single-cycle ack and abort.
// Define ADDR_DEC_ERR_EN to complete unmapped requests with ack+error instead of ignoring them.
module address_decoder_sync #(
    parameter int ADDR_WIDTH  = 3,
    parameter int NUM_TARGETS = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  resetN,
    address_decoder_sync_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SELECT = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    localparam logic [ADDR_WIDTH:0] MAP_LIMIT = (ADDR_WIDTH + 1)'(NUM_TARGETS);
    localparam logic [3:0]          WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]             state_r, state_s;
    logic [3:0]             cnt_r, cnt_s;
    logic [ADDR_WIDTH-1:0]  addr_r, addr_s;
    logic [NUM_TARGETS-1:0] dec_r, dec_s;
    logic                   ack_r, ack_s;
    logic                   busy_r, busy_s;
    logic                   err_s;
    logic                   mapped_s;

    function automatic logic [NUM_TARGETS-1:0] onehot(input logic [ADDR_WIDTH-1:0] a);
        logic [NUM_TARGETS-1:0] res;
        res = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            res[i] = (a == ADDR_WIDTH'(i));
        end
        return res;
    endfunction

    // Address is mapped when it lies below the target count.
    always_comb begin
        mapped_s = ({1'b0, bus.addressIn} < MAP_LIMIT);
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead so they leave flops.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        addr_s  = addr_r;
        dec_s   = dec_r;
        ack_s   = 1'b0;
        busy_s  = busy_r;
        err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.request && mapped_s) begin
                    state_s = ST_SELECT;
                    addr_s  = bus.addressIn;
                    cnt_s   = WAIT_INIT;
                    dec_s   = onehot(bus.addressIn);
                    busy_s  = 1'b1;
                end
`ifdef ADDR_DEC_ERR_EN
                else if (bus.request) begin
                    state_s = ST_ACK;
                    dec_s   = '0;
                    ack_s   = 1'b1;
                    err_s   = 1'b1;
                    busy_s  = 1'b1;
                end
`endif
                else begin
                    dec_s  = '0;
                    busy_s = 1'b0;
                end
            end
            ST_SELECT: begin
                if (!bus.request) begin
                    // Abort: drop the select on this edge and discard the wait count.
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                    dec_s   = '0;
                    busy_s  = 1'b0;
                end else if (cnt_r == 4'd0) begin
                    state_s = ST_ACK;
                    dec_s   = '0;
                    ack_s   = 1'b1;
                    busy_s  = 1'b1;
                end else begin
                    cnt_s  = cnt_r - 4'd1;
                    dec_s  = onehot(addr_r);
                    busy_s = 1'b1;
                end
            end
            ST_ACK: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
                dec_s   = '0;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
                dec_s   = '0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and registered outputs with asynchronous active-low reset.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            addr_r  <= '0;
            dec_r   <= '0;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            addr_r  <= addr_s;
            dec_r   <= dec_s;
            ack_r   <= ack_s;
            busy_r  <= busy_s;
        end
    end

`ifdef ADDR_DEC_ERR_EN
    logic err_r;

    // Error flag qualifies the ack of an unmapped request.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_s;
        end
    end

    assign bus.error = err_r;
`else
    assign bus.error = 1'b0;
`endif

    assign bus.decodedAddress = dec_r;
    assign bus.ack            = ack_r;
    assign bus.busy           = busy_r;
endmodule

// File: tb/tb_address_decoder_sync.sv
// Directed self-checking bench: several decoder instances with different wait/target settings.
module tb_address_decoder_sync;
    logic clock;
    logic resetN;
    int   total;
    int   bad;

    address_decoder_sync_if #(.ADDR_WIDTH(3), .NUM_TARGETS(8)) ba ();
    address_decoder_sync_if #(.ADDR_WIDTH(3), .NUM_TARGETS(8)) bb ();
    address_decoder_sync_if #(.ADDR_WIDTH(3), .NUM_TARGETS(8)) bc ();
    address_decoder_sync_if #(.ADDR_WIDTH(3), .NUM_TARGETS(8)) bd ();
    address_decoder_sync_if #(.ADDR_WIDTH(3), .NUM_TARGETS(5)) be ();

    address_decoder_sync #(.ADDR_WIDTH(3), .NUM_TARGETS(8), .WAIT_CYCLES(1))
        dut_a (.clock(clock), .resetN(resetN), .bus(ba));
    address_decoder_sync #(.ADDR_WIDTH(3), .NUM_TARGETS(8), .WAIT_CYCLES(0))
        dut_b (.clock(clock), .resetN(resetN), .bus(bb));
    address_decoder_sync #(.ADDR_WIDTH(3), .NUM_TARGETS(8), .WAIT_CYCLES(4))
        dut_c (.clock(clock), .resetN(resetN), .bus(bc));
    address_decoder_sync #(.ADDR_WIDTH(3), .NUM_TARGETS(8), .WAIT_CYCLES(3))
        dut_d (.clock(clock), .resetN(resetN), .bus(bd));
    address_decoder_sync #(.ADDR_WIDTH(3), .NUM_TARGETS(5), .WAIT_CYCLES(1))
        dut_e (.clock(clock), .resetN(resetN), .bus(be));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock edge, then settle at the falling edge where outputs are sampled.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        ba.request = 1'b0; bb.request = 1'b0; bc.request = 1'b0; bd.request = 1'b0; be.request = 1'b0;
        ba.addressIn = 3'd0; bb.addressIn = 3'd0; bc.addressIn = 3'd0; bd.addressIn = 3'd0; be.addressIn = 3'd0;
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        tick();
        total++;
        if ({ba.decodedAddress, ba.ack, ba.error, ba.busy} !== 11'd0) begin
            bad++; $display("FAIL reset_a: got %b want 0", {ba.decodedAddress, ba.ack, ba.error, ba.busy});
        end
        total++;
        if ({be.decodedAddress, be.ack, be.error, be.busy} !== 8'd0) begin
            bad++; $display("FAIL reset_e: got %b want 0", {be.decodedAddress, be.ack, be.error, be.busy});
        end
    endtask

    task automatic test_basic();
        ba.addressIn = 3'b101;
        ba.request   = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            tick();
            total++;
            if (ba.decodedAddress !== 8'b0010_0000 || ba.ack !== 1'b0 || ba.busy !== 1'b1) begin
                bad++; $display("FAIL basic_sel c%0d: dec=%b ack=%b busy=%b want 00100000/0/1",
                                c, ba.decodedAddress, ba.ack, ba.busy);
            end
        end
        tick();
        total++;
        if (ba.ack !== 1'b1 || ba.decodedAddress !== 8'd0 || ba.error !== 1'b0 || ba.busy !== 1'b1) begin
            bad++; $display("FAIL basic_ack: ack=%b dec=%b err=%b busy=%b want 1/0/0/1",
                            ba.ack, ba.decodedAddress, ba.error, ba.busy);
        end
        ba.request = 1'b0;
        tick();
        total++;
        if (ba.busy !== 1'b0 || ba.ack !== 1'b0) begin
            bad++; $display("FAIL basic_idle: busy=%b ack=%b want 0/0", ba.busy, ba.ack);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] exp_dec;
        bb.addressIn = 3'd0;
        bb.request   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_dec = 8'd1 << i;
            tick();
            total++;
            if (bb.decodedAddress !== exp_dec || bb.ack !== 1'b0) begin
                bad++; $display("FAIL sweep_sel a%0d: dec=%b ack=%b want %b/0", i, bb.decodedAddress, bb.ack, exp_dec);
            end
            bb.addressIn = 3'(i + 1);
            tick();
            total++;
            if (bb.ack !== 1'b1 || bb.decodedAddress !== 8'd0) begin
                bad++; $display("FAIL sweep_ack a%0d: ack=%b dec=%b want 1/0", i, bb.ack, bb.decodedAddress);
            end
            tick();
            total++;
            if (bb.ack !== 1'b0 || bb.busy !== 1'b0 || bb.decodedAddress !== 8'd0) begin
                bad++; $display("FAIL sweep_gap a%0d: ack=%b busy=%b dec=%b want 0/0/0",
                                i, bb.ack, bb.busy, bb.decodedAddress);
            end
            if (i == 7) bb.request = 1'b0;
        end
        tick();
        total++;
        if (bb.busy !== 1'b0) begin
            bad++; $display("FAIL sweep_end: busy=%b want 0", bb.busy);
        end
    endtask

    task automatic test_abort();
        logic seen_ack;
        bc.addressIn = 3'd2;
        bc.request   = 1'b1;
        tick();
        tick();
        total++;
        if (bc.decodedAddress !== 8'b0000_0100) begin
            bad++; $display("FAIL abort_sel: dec=%b want 00000100", bc.decodedAddress);
        end
        bc.request = 1'b0;
        tick();
        total++;
        if (bc.decodedAddress !== 8'd0 || bc.busy !== 1'b0 || bc.ack !== 1'b0) begin
            bad++; $display("FAIL abort_clear: dec=%b busy=%b ack=%b want 0/0/0",
                            bc.decodedAddress, bc.busy, bc.ack);
        end
        seen_ack = 1'b0;
        repeat (8) begin
            tick();
            if (bc.ack !== 1'b0 || bc.busy !== 1'b0) seen_ack = 1'b1;
        end
        total++;
        if (seen_ack !== 1'b0) begin
            bad++; $display("FAIL abort_noack: activity=%b want 0", seen_ack);
        end
    endtask

    task automatic test_unmapped();
        be.addressIn = 3'd6;
        be.request   = 1'b1;
`ifdef ADDR_DEC_ERR_EN
        tick();
        total++;
        if (be.ack !== 1'b1 || be.error !== 1'b1 || be.decodedAddress !== 5'd0) begin
            bad++; $display("FAIL unmapped_err: ack=%b err=%b dec=%b want 1/1/0", be.ack, be.error, be.decodedAddress);
        end
        be.request = 1'b0;
        tick();
        total++;
        if (be.ack !== 1'b0 || be.error !== 1'b0 || be.busy !== 1'b0) begin
            bad++; $display("FAIL unmapped_done: ack=%b err=%b busy=%b want 0/0/0", be.ack, be.error, be.busy);
        end
`else
        begin
            logic activity;
            activity = 1'b0;
            repeat (20) begin
                tick();
                if (be.ack !== 1'b0 || be.busy !== 1'b0 || be.error !== 1'b0 || be.decodedAddress !== 5'd0)
                    activity = 1'b1;
            end
            total++;
            if (activity !== 1'b0) begin
                bad++; $display("FAIL unmapped_ignore: activity=%b want 0", activity);
            end
            be.request = 1'b0;
        end
`endif
        be.addressIn = 3'd4;
        be.request   = 1'b1;
        tick();
        total++;
        if (be.decodedAddress !== 5'b10000 || be.error !== 1'b0) begin
            bad++; $display("FAIL mapped_top: dec=%b err=%b want 10000/0", be.decodedAddress, be.error);
        end
        be.request = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bd.addressIn = 3'd7;
        bd.request   = 1'b1;
        tick();
        total++;
        if (bd.decodedAddress !== 8'b1000_0000) begin
            bad++; $display("FAIL rstmid_sel: dec=%b want 10000000", bd.decodedAddress);
        end
        tick();
        #2 resetN = 1'b0;
        #1;
        total++;
        if ({bd.decodedAddress, bd.ack, bd.error, bd.busy} !== 11'd0) begin
            bad++; $display("FAIL rstmid_async: got %b want 0", {bd.decodedAddress, bd.ack, bd.error, bd.busy});
        end
        bd.request = 1'b0;
        @(negedge clock);
        resetN = 1'b1;
        bd.addressIn = 3'd3;
        bd.request   = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            total++;
            if (bd.decodedAddress !== 8'b0000_1000 || bd.ack !== 1'b0) begin
                bad++; $display("FAIL rstmid_resume c%0d: dec=%b ack=%b want 00001000/0", c, bd.decodedAddress, bd.ack);
            end
        end
        tick();
        total++;
        if (bd.ack !== 1'b1 || bd.decodedAddress !== 8'd0) begin
            bad++; $display("FAIL rstmid_ack: ack=%b dec=%b want 1/0", bd.ack, bd.decodedAddress);
        end
        bd.request = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        ba.addressIn = 3'd1;
        ba.request   = 1'b1;
        tick();
        ba.addressIn = 3'd6;
        tick();
        total++;
        if (ba.decodedAddress !== 8'b0000_0010) begin
            bad++; $display("FAIL held_addr_change: dec=%b want 00000010", ba.decodedAddress);
        end
        tick();
        total++;
        if (ba.ack !== 1'b1) begin
            bad++; $display("FAIL held_ack: ack=%b want 1", ba.ack);
        end
        ba.addressIn = 3'd4;
        tick();
        total++;
        if (ba.busy !== 1'b0 || ba.decodedAddress !== 8'd0) begin
            bad++; $display("FAIL held_gap: busy=%b dec=%b want 0/0", ba.busy, ba.decodedAddress);
        end
        tick();
        total++;
        if (ba.decodedAddress !== 8'b0001_0000 || ba.busy !== 1'b1) begin
            bad++; $display("FAIL held_restart: dec=%b busy=%b want 00010000/1", ba.decodedAddress, ba.busy);
        end
        ba.request = 1'b0;
        tick();
        total++;
        if (ba.busy !== 1'b0 || ba.ack !== 1'b0 || ba.decodedAddress !== 8'd0) begin
            bad++; $display("FAIL held_abort: busy=%b ack=%b dec=%b want 0/0/0", ba.busy, ba.ack, ba.decodedAddress);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_sweep();
        test_abort();
        test_unmapped();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
